// File: rtl/button_debounce.sv
// Per-button 2-flop synchronizer, counter-based debouncer and auto-repeat FSM.
// Press/release/repeat are registered one-cycle pulses aligned to btn_level.
module button_debounce #(
  parameter int unsigned N         = 4,
  parameter int unsigned DB_CYCLES = 50000,
  parameter int unsigned RPT_DELAY = 25000000,
  parameter int unsigned RPT_RATE  = 5000000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] btn_raw,
  output logic [N-1:0] btn_level,
  output logic [N-1:0] btn_press,
  output logic [N-1:0] btn_release,
  output logic [N-1:0] btn_repeat,
  output logic         any_press
);

  localparam int unsigned DBW     = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam int unsigned RPT_MAX = (RPT_DELAY > RPT_RATE) ? RPT_DELAY : RPT_RATE;
  localparam int unsigned RW      = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;

  localparam logic [DBW-1:0] DB_LAST = DBW'(DB_CYCLES - 1);
  localparam logic [RW-1:0]  RD_LAST = RW'(RPT_DELAY - 1);
  localparam logic [RW-1:0]  RR_LAST = RW'(RPT_RATE - 1);

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    REPEAT
  } rpt_state_t;

  logic [N-1:0] sync1;
  logic [N-1:0] sync2;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      any_press <= 1'b0;
    end else begin
      any_press <= |btn_press;
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_bit
    logic           lvl_q;
    logic           press_q;
    logic           rel_q;
    logic           rpt_q;
    logic [DBW-1:0] db_cnt;
    logic           db_done;
    logic           rise;
    logic           fall;
    rpt_state_t     state_q;
    rpt_state_t     state_d;
    logic [RW-1:0]  rpt_cnt_q;
    logic [RW-1:0]  rpt_cnt_d;
    logic           rpt_d;

    assign db_done = (sync2[i] != lvl_q) && (db_cnt == DB_LAST);
    assign rise    = db_done & ~lvl_q;
    assign fall    = db_done & lvl_q;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        lvl_q   <= 1'b0;
        press_q <= 1'b0;
        rel_q   <= 1'b0;
        db_cnt  <= '0;
      end else begin
        press_q <= rise;
        rel_q   <= fall;
        if ((sync2[i] == lvl_q) || db_done) begin
          db_cnt <= '0;
        end else begin
          db_cnt <= db_cnt + DBW'(1);
        end
        if (db_done) begin
          lvl_q <= ~lvl_q;
        end
      end
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        state_q   <= IDLE;
        rpt_cnt_q <= '0;
        rpt_q     <= 1'b0;
      end else begin
        state_q   <= state_d;
        rpt_cnt_q <= rpt_cnt_d;
        rpt_q     <= rpt_d;
      end
    end

    // FSM reacts to the debounce event itself, so it moves on the same edge
    // that registers the press/release pulse; release overrides any repeat.
    always_comb begin
      state_d   = state_q;
      rpt_cnt_d = rpt_cnt_q;
      rpt_d     = 1'b0;
      if (fall) begin
        state_d   = IDLE;
        rpt_cnt_d = '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (rise && (RPT_DELAY != 0)) begin
              state_d   = DELAY;
              rpt_cnt_d = '0;
            end
          end
          DELAY: begin
            if (rpt_cnt_q == RD_LAST) begin
              rpt_d     = 1'b1;
              rpt_cnt_d = '0;
              state_d   = REPEAT;
            end else begin
              rpt_cnt_d = rpt_cnt_q + RW'(1);
            end
          end
          REPEAT: begin
            if (rpt_cnt_q == RR_LAST) begin
              rpt_d     = 1'b1;
              rpt_cnt_d = '0;
            end else begin
              rpt_cnt_d = rpt_cnt_q + RW'(1);
            end
          end
          default: begin
            state_d   = IDLE;
            rpt_cnt_d = '0;
          end
        endcase
      end
    end

    assign btn_level[i]   = lvl_q;
    assign btn_press[i]   = press_q;
    assign btn_release[i] = rel_q;
    assign btn_repeat[i]  = rpt_q;
  end

endmodule

// File: tb/tb_button_debounce.sv
// Scoreboard bench for button_debounce: a sliding-window/elapsed-time model
// pushes expected outputs per cycle; a monitor pops and compares them.
module tb_button_debounce;

  localparam int N  = 4;
  localparam int DB = 4;
  localparam int RD = 10;
  localparam int RR = 3;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] btn_raw;
  logic [N-1:0] btn_level;
  logic [N-1:0] btn_press;
  logic [N-1:0] btn_release;
  logic [N-1:0] btn_repeat;
  logic         any_press;

  typedef struct packed {
    logic [N-1:0] level;
    logic [N-1:0] press;
    logic [N-1:0] rel;
    logic [N-1:0] rpt;
    logic         any;
  } exp_t;

  exp_t         exp_q[$];
  int           n_cmp = 0;
  int           n_err = 0;

  logic [N-1:0] hist[$];
  logic [N-1:0] m_lvl;
  logic [N-1:0] m_prev;
  int           m_t;
  int           m_press_t[N];

  button_debounce #(
    .N        (N),
    .DB_CYCLES(DB),
    .RPT_DELAY(RD),
    .RPT_RATE (RR)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_raw    (btn_raw),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .btn_repeat (btn_repeat),
    .any_press  (any_press)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [4*N:0] act, input logic [4*N:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: lvl/prs/rel/rpt/any got %h required %h", name, act, req);
    end
  endtask

  // Synced value seen by the logic at edge k is the raw sample from edge k-2.
  function automatic logic samp(input int idx, input int b);
    logic [N-1:0] v;
    if (idx < 0) return 1'b0;
    v = hist[idx];
    return v[b];
  endfunction

  function automatic void model_step(input logic rst_v, input logic [N-1:0] raw_v);
    exp_t e;
    logic all_diff;
    int   d;
    e = '0;
    if (!rst_v) begin
      hist.delete();
      m_lvl  = '0;
      m_prev = '0;
      m_t    = 0;
      exp_q.push_back(e);
      return;
    end
    hist.push_back(raw_v);
    for (int b = 0; b < N; b++) begin
      all_diff = 1'b1;
      for (int j = 0; j < DB; j++) begin
        if (samp(m_t - 2 - j, b) == m_lvl[b]) all_diff = 1'b0;
      end
      if (all_diff) begin
        if (m_lvl[b]) begin
          e.rel[b] = 1'b1;
        end else begin
          e.press[b]   = 1'b1;
          m_press_t[b] = m_t;
        end
        m_lvl[b] = ~m_lvl[b];
      end
      if (m_lvl[b] && !e.press[b]) begin
        d = m_t - m_press_t[b];
        if (d == RD || (d > RD && (d - RD) % RR == 0)) e.rpt[b] = 1'b1;
      end
    end
    e.level = m_lvl;
    e.any   = |m_prev;
    m_prev  = e.press;
    m_t++;
    exp_q.push_back(e);
  endfunction

  task automatic step(input logic rst_v, input logic [N-1:0] raw_v);
    @(negedge clk);
    reset   = rst_v;
    btn_raw = raw_v;
    model_step(rst_v, raw_v);
  endtask

  task automatic hold(input logic [N-1:0] raw_v, input int cycles);
    for (int i = 0; i < cycles; i++) step(1'b1, raw_v);
  endtask

  // Reset asserted between edges must clear every output immediately.
  task automatic async_reset(input string name);
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check(name, {btn_level, btn_press, btn_release, btn_repeat, any_press}, '0);
  endtask

  initial begin : monitor
    exp_t e;
    int   k;
    k = 0;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check($sformatf("cycle%0d", k),
              {btn_level, btn_press, btn_release, btn_repeat, any_press}, e);
        k++;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required bench completion");
    $fatal(1);
  end

  initial begin : stimulus
    logic [N-1:0] r;
    int           left[N];
    reset   = 1'b0;
    btn_raw = '0;
    for (int i = 0; i < 3; i++) step(1'b0, '0);

    hold(4'b0001, 20);          // clean press
    hold(4'b0000, 15);
    hold(4'b0010, 3);           // short glitch
    hold(4'b0000, 20);
    hold(4'b0100, 40);          // auto-repeat
    hold(4'b0000, 15);
    hold(4'b0100, 16);          // release lands on a repeat edge
    hold(4'b0000, 15);
    hold(4'b1011, 12);          // simultaneous press
    hold(4'b0000, 15);

    hold(4'b1000, 18);          // reset mid-repeat-delay while held
    async_reset("async_rst_held");
    for (int i = 0; i < 3; i++) step(1'b0, 4'b1000);
    hold(4'b1000, 30);
    hold(4'b0000, 15);

    hold(4'b0001, 3);           // reset mid-debounce
    async_reset("async_rst_debounce");
    for (int i = 0; i < 2; i++) step(1'b0, 4'b0000);
    hold(4'b0000, 12);

    r = '0;
    for (int b = 0; b < N; b++) left[b] = $urandom_range(1, 25);
    for (int c = 0; c < 800; c++) begin
      for (int b = 0; b < N; b++) begin
        if (left[b] == 0) begin
          r[b]    = ~r[b];
          left[b] = $urandom_range(1, 30);
        end else begin
          left[b]--;
        end
      end
      if ($urandom_range(0, 299) == 0) begin
        step(1'b0, r);
        step(1'b0, r);
      end else begin
        step(1'b1, r);
      end
    end
    hold(4'b0000, 20);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #3;
    if (exp_q.size() > 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/button_debounce.md
BUTTON_DEBOUNCE -- requirements
Module: button_debounce

Interface
REQ-001 The block SHALL have these parameters.
- N, 4: number of independent button inputs.
- DB_CYCLES, 50000: consecutive stable sampled cycles required to accept a level change (>=1).
- RPT_DELAY, 25000000: cycles a button is held before the first repeat pulse; 0 disables auto-repeat.
- RPT_RATE, 5000000: cycles between subsequent repeat pulses (>=1).

REQ-002 The block SHALL have these ports, in this order.
- clk, input, 1: single system clock; all flops on the rising edge.
- reset, input, 1: asynchronous, active-low reset.
- btn_raw, input, N: raw asynchronous button/switch levels; 1 = pressed.
- btn_level, output, N: debounced, registered level per button.
- btn_press, output, N: one-cycle pulse on each accepted 0->1 level change.
- btn_release, output, N: one-cycle pulse on each accepted 1->0 level change.
- btn_repeat, output, N: one-cycle auto-repeat pulse while a button is held.
- any_press, output, 1: registered OR-reduce of btn_press.

Function
REQ-003 Each btn_raw bit SHALL pass through a 2-flop synchronizer; only the second flop (sync) feeds the logic.
REQ-004 Each bit SHALL have its own counter, sized to hold DB_CYCLES-1, that clears whenever sync equals btn_level.
REQ-005 While sync differs from btn_level, the counter SHALL increment once per cycle.
REQ-006 On the edge where sync has differed for DB_CYCLES consecutive cycles, btn_level SHALL toggle and the counter SHALL clear.
REQ-007 Any glitch shorter than DB_CYCLES cycles SHALL produce no change on any output.
REQ-008 Latency from a clean btn_raw edge to btn_level SHALL be exactly 2 + DB_CYCLES cycles.
REQ-009 btn_press and btn_release SHALL be high for exactly one cycle, namely the first cycle in which btn_level shows the new value.
REQ-010 Each bit SHALL run an independent auto-repeat FSM with states IDLE, DELAY and REPEAT, plus one counter per bit.
REQ-011 IDLE SHALL move to DELAY on btn_press, with the counter cleared, only if RPT_DELAY != 0.
REQ-012 In DELAY, when the counter reaches RPT_DELAY-1, the FSM SHALL pulse btn_repeat for one cycle, clear the counter and move to REPEAT.
REQ-013 In REPEAT, btn_repeat SHALL pulse for one cycle every RPT_RATE cycles.
REQ-014 The first repeat pulse SHALL occur RPT_DELAY cycles after btn_press, and each later pulse SHALL follow the previous one by RPT_RATE cycles.
REQ-015 A btn_release in any state SHALL return the FSM to IDLE on the same edge.
REQ-016 No btn_repeat pulse SHALL occur in the cycle btn_release is high or in any later cycle until the next press.
REQ-017 If btn_release coincides with a scheduled repeat edge, the release SHALL win and no repeat pulse SHALL be emitted.
REQ-018 Bits SHALL be fully independent; simultaneous presses on several bits SHALL each produce their own pulses in the same cycle.
REQ-019 any_press SHALL equal the OR of btn_press delayed by one register stage.
REQ-020 btn_press, btn_release and btn_repeat SHALL never be high for the same bit in the same cycle.

Reset
REQ-021 While reset=0, all synchronizer flops, debounce counters, repeat counters and outputs SHALL be 0, and every FSM SHALL be in IDLE, regardless of clk.
REQ-022 After reset deasserts, a button already held SHALL be treated as a new press: btn_level rises 2 + DB_CYCLES cycles later with a btn_press pulse.
REQ-023 Reset asserted mid-debounce or mid-repeat SHALL abort the operation with no pending pulse emitted after release.

Verification
REQ-024 The bench SHALL use N=4, DB_CYCLES=4, RPT_DELAY=10, RPT_RATE=3 and cover these scenarios.
- Clean press: btn_raw[0] 0->1 at cycle 0 -> btn_level[0]=1 and btn_press[0]=1 at cycle 6 only; other bits stay 0.
- Glitch: btn_raw[1] high for 3 cycles, then low -> all outputs stay 0 for 20 cycles.
- Auto-repeat: hold btn_raw[2] -> btn_press at cycle T, btn_repeat at T+10, T+13, T+16, and so on.
- Release at a repeat edge: btn_release coinciding with a scheduled repeat edge -> btn_release=1, btn_repeat=0, FSM IDLE, no further repeats.
- Simultaneous press: btn_raw=4'b1011 at cycle 0 -> btn_press=4'b1011 at cycle 6, any_press=1 at cycle 7.
- Reset while held: reset=0 during a hold with btn_raw[3]=1 -> outputs 0 at once; after release, btn_level[3]=1 and btn_press[3] pulse at 6 cycles.
